// File: rtl/interval_timer_bank_pkg.sv
// Shared definitions for the interval timer bank: default widths, the layout of
// the per-channel mode word, and the channel-select width helper.
package interval_timer_bank_pkg;

    localparam int unsigned NCH_DEF   = 4;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned PRE_W_DEF = 8;

    localparam int unsigned MODE_W          = 2;
    localparam int unsigned MODE_EN_BIT     = 0;
    localparam int unsigned MODE_ONESHOT_BIT = 1;

    // Select width needed to address n channels (never narrower than 1 bit).
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/interval_timer_bank_if.sv
// Processor-side bus of the timer bank: prescaler, channel configuration,
// interrupt acknowledge and the fire/pending/count status returned.
interface interval_timer_bank_if
    import interval_timer_bank_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF,
    parameter int unsigned CH_W  = ch_idx_w(NCH)
);
    logic [PRE_W-1:0] prescale;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_en;
    logic             cfg_oneshot;
    logic [NCH-1:0]   ack;
    logic [NCH-1:0]   fire;
    logic [NCH-1:0]   pending;
    logic             irq_any;
    logic [CNT_W-1:0] rd_count;

    modport master (
        output prescale, cfg_we, cfg_ch, cfg_period, cfg_en, cfg_oneshot, ack,
        input  fire, pending, irq_any, rd_count
    );

    modport slave (
        input  prescale, cfg_we, cfg_ch, cfg_period, cfg_en, cfg_oneshot, ack,
        output fire, pending, irq_any, rd_count
    );

endinterface

// File: rtl/interval_timer_bank_channel.sv
// One timer channel: period/mode registers, tick-driven counter, one-cycle
// fire pulse and sticky pending flag.
module timer_channel
    import interval_timer_bank_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk_25mhz,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_tick,
    input  logic [CNT_W-1:0]  i_period,
    input  logic [MODE_W-1:0] i_mode,
    input  logic              i_ack,
    output logic              o_fire,
    output logic              o_pending,
    output logic [CNT_W-1:0]  o_count
);
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_period;
    logic [MODE_W-1:0] r_mode;
    logic              r_fire;
    logic              r_pending;
    logic              w_run;

    assign w_run = r_mode[MODE_EN_BIT] && i_tick && (r_period != '0);

    // Pending set is assigned after the ack clear so a coincident expiry wins.
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            r_cnt     <= '0;
            r_period  <= '0;
            r_mode    <= '0;
            r_fire    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_fire <= 1'b0;
            if (i_ack) r_pending <= 1'b0;
            if (i_we) begin
                r_period <= i_period;
                r_mode   <= i_mode;
                r_cnt    <= '0;
            end else if (w_run && (r_cnt == r_period)) begin
                r_cnt     <= '0;
                r_fire    <= 1'b1;
                r_pending <= 1'b1;
                if (r_mode[MODE_ONESHOT_BIT]) r_mode[MODE_EN_BIT] <= 1'b0;
            end else if (w_run) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_fire    = r_fire;
    assign o_pending = r_pending;
    assign o_count   = r_cnt;

endmodule

// File: rtl/interval_timer_bank.sv
// Bank of NCH interval timers sharing one prescaler; holds the prescaler,
// configuration decode, ack fan-out, count read-back mux and interrupt OR.
module interval_timer_bank
    import interval_timer_bank_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF,
    parameter int unsigned CH_W  = ch_idx_w(NCH)
) (
    input  logic                 clk_25mhz,
    input  logic                 rst,
    interval_timer_bank_if.slave bus
);
    logic [PRE_W-1:0]  r_pcnt;
    logic              w_tick;
    logic [MODE_W-1:0] w_mode;
    logic [NCH-1:0]    w_we;
    logic [NCH-1:0]    w_fire;
    logic [NCH-1:0]    w_pending;
    logic [CNT_W-1:0]  w_count [NCH];
    logic [CNT_W-1:0]  w_rd;

    // Equality compare means a prescale lowered below pcnt waits for the wrap.
    assign w_tick = (r_pcnt == bus.prescale);

    always_ff @(posedge clk_25mhz) begin
        if (rst || w_tick) r_pcnt <= '0;
        else               r_pcnt <= r_pcnt + PRE_W'(1);
    end

    always_comb begin
        w_mode                   = '0;
        w_mode[MODE_EN_BIT]      = bus.cfg_en;
        w_mode[MODE_ONESHOT_BIT] = bus.cfg_oneshot;
    end

    // Selects at or above NCH match no channel: writes drop, read-back is 0.
    always_comb begin
        w_we = '0;
        w_rd = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.cfg_ch == CH_W'(i)) begin
                w_we[i] = bus.cfg_we;
                w_rd    = w_count[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk_25mhz (clk_25mhz),
            .rst       (rst),
            .i_we      (w_we[g]),
            .i_tick    (w_tick),
            .i_period  (bus.cfg_period),
            .i_mode    (w_mode),
            .i_ack     (bus.ack[g]),
            .o_fire    (w_fire[g]),
            .o_pending (w_pending[g]),
            .o_count   (w_count[g])
        );
    end

    assign bus.fire     = w_fire;
    assign bus.pending  = w_pending;
    assign bus.irq_any  = |w_pending;
    assign bus.rd_count = w_rd;

endmodule

// File: tb/tb_interval_timer_bank.sv
// Directed bench for interval_timer_bank: fire timing, one-shot, ack/set
// priority, reconfiguration, out-of-range select and mid-count reset.
module tb_interval_timer_bank;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   t_pre  = 0;
    int   n;
    int   w_edge;
    int   w1_edge;
    int   w3_edge;
    int   k;
    logic [3:0] fire_seen;

    interval_timer_bank_if #(.NCH(4), .CNT_W(16), .PRE_W(8), .CH_W(3)) bus ();

    interval_timer_bank #(.NCH(4), .CNT_W(16), .PRE_W(8), .CH_W(3)) dut (
        .clk_25mhz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic step();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input int period, input bit en, input bit oneshot);
        bus.cfg_ch      = 3'(ch);
        bus.cfg_period  = 16'(period);
        bus.cfg_en      = en;
        bus.cfg_oneshot = oneshot;
        bus.cfg_we      = 1'b1;
        step();
        bus.cfg_we      = 1'b0;
    endtask

    task automatic wait_fire(input int ch, input int max, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (bus.fire[ch] !== 1'b1 && cnt < max);
    endtask

    // With prescale 3 the prescaler ticks on edges t_pre+3, t_pre+7, ...
    function automatic bit is_tick(input int e);
        return ((e - t_pre) % 4) == 3;
    endfunction

    function automatic int first_tick_after(input int e);
        for (int d = 1; d <= 4; d++)
            if (is_tick(e + d)) return d;
        return 0;
    endfunction

    function automatic int ticks_in(input int a, input int b);
        int c = 0;
        for (int x = a + 1; x <= b; x++)
            if (is_tick(x)) c++;
        return c;
    endfunction

    initial begin
        rst             = 1'b1;
        bus.prescale    = '0;
        bus.cfg_we      = 1'b0;
        bus.cfg_ch      = '0;
        bus.cfg_period  = '0;
        bus.cfg_en      = 1'b0;
        bus.cfg_oneshot = 1'b0;
        bus.ack         = '0;
        step();
        step();
        rst = 1'b0;

        // Idle after reset
        fire_seen = '0;
        repeat (200) begin
            step();
            fire_seen |= bus.fire;
        end
        chk("idle_fire", fire_seen, 0);
        chk("idle_pending", bus.pending, 0);
        chk("idle_irq", bus.irq_any, 0);
        chk("idle_rd", bus.rd_count, 0);

        // Periodic ch0, prescale 0
        cfg_write(0, 80, 1'b1, 1'b0);
        chk("t2_cnt_after_write", bus.rd_count, 0);
        wait_fire(0, 200, n);
        chk("t2_first_fire", n, 81);
        chk("t2_pending", bus.pending[0], 1);
        chk("t2_irq", bus.irq_any, 1);
        wait_fire(0, 200, n);
        chk("t2_spacing", n, 81);
        step();
        chk("t2_fire_width", bus.fire[0], 0);
        bus.ack = 4'b0001;
        step();
        bus.ack = '0;
        chk("t2_ack_clear", bus.pending[0], 0);

        // One-shot ch1, prescale 3; write lands on a tick edge
        bus.prescale = 8'd3;
        step();
        t_pre = edge_n;
        step();
        step();
        cfg_write(1, 5, 1'b1, 1'b1);
        wait_fire(1, 100, n);
        chk("t3_oneshot_fire", n, 24);
        chk("t3_pending", bus.pending[1], 1);
        fire_seen = '0;
        repeat (500) begin
            step();
            fire_seen |= bus.fire;
        end
        chk("t3_no_refire", fire_seen[1], 0);
        bus.cfg_ch = 3'd1;
        chk("t3_cnt_idle", bus.rd_count, 0);

        // ch2 periodic: ack coinciding with fire
        cfg_write(2, 10, 1'b1, 1'b0);
        w_edge = edge_n;
        wait_fire(2, 100, n);
        chk("t4_first_fire", n, first_tick_after(w_edge) + 40);
        bus.ack = 4'b0100;
        step();
        bus.ack = '0;
        chk("t4_lone_ack", bus.pending[2], 0);
        repeat (42) step();
        bus.ack = 4'b0100;
        step();
        bus.ack = '0;
        chk("t4_coincide_fire", bus.fire[2], 1);
        chk("t4_coincide_pending", bus.pending[2], 1);
        step();
        chk("t4_hold", bus.pending[2], 1);
        bus.ack = 4'b0100;
        step();
        bus.ack = '0;
        chk("t4_later_ack", bus.pending[2], 0);

        // Rewrite ch0 mid-count; out-of-range select
        bus.cfg_ch = 3'd0;
        wait_fire(0, 400, n);
        chk("t5_pending_set", bus.pending[0], 1);
        k = 0;
        while (bus.rd_count !== 16'd40 && k < 400) begin
            step();
            k++;
        end
        chk("t5_reach40", bus.rd_count, 40);
        cfg_write(0, 20, 1'b1, 1'b0);
        w_edge = edge_n;
        chk("t5_restart", bus.rd_count, 0);
        chk("t5_pending_kept", bus.pending[0], 1);
        wait_fire(0, 200, n);
        chk("t5_first_fire", n, first_tick_after(w_edge) + 80);
        cfg_write(4, 7, 1'b1, 1'b0);
        chk("t5_rd_oob", bus.rd_count, 0);
        bus.cfg_ch = 3'd3;
        chk("t5_ch3_untouched", bus.rd_count, 0);
        bus.cfg_ch = 3'd0;
        wait_fire(0, 200, n);
        chk("t5_spacing", n + 1, 84);

        // Reset with all channels mid-count
        cfg_write(1, 100, 1'b1, 1'b0);
        w1_edge = edge_n;
        cfg_write(3, 50, 1'b1, 1'b0);
        w3_edge = edge_n;
        repeat (30) step();
        bus.cfg_ch = 3'd1;
        chk("t6_ch1_cnt", bus.rd_count, ticks_in(w1_edge, edge_n));
        bus.cfg_ch = 3'd3;
        chk("t6_ch3_cnt", bus.rd_count, ticks_in(w3_edge, edge_n));
        rst = 1'b1;
        step();
        chk("t6_fire_on_rst", bus.fire, 0);
        chk("t6_pending", bus.pending, 0);
        chk("t6_irq", bus.irq_any, 0);
        for (int c = 0; c < 4; c++) begin
            bus.cfg_ch = 3'(c);
            #1;
            chk($sformatf("t6_cnt%0d", c), bus.rd_count, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        fire_seen = '0;
        repeat (100) begin
            step();
            fire_seen |= bus.fire;
        end
        chk("t6_no_fire_after", fire_seen, 0);
        chk("t6_pending_after", bus.pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
